// File: rtl/stage_ma_mem.sv
// Memory-access stage: ALU writeback or req/ack data-memory transaction.
// Stalls the EX/MA register while a transaction is in flight.
module stage_ma_mem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] busc_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic [4:0]  rd_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] result_out,
  output logic [4:0]  rd_out,
  output logic        wb_valid_out,
  output logic        fault_out
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

  logic [0:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   res_q, res_d;
  logic [4:0]    rd_q, rd_d;
  logic          wbv_q, wbv_d;
  logic          flt_q, flt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rdp_q, rdp_d;

  logic        is_mem, both, f3_ok, misal, bad;
  logic        accept, expire;
  logic [31:0] wd_n, sh_data;
  logic [3:0]  be_n;
  logic [31:0] ld_val;

  always_comb begin
    is_mem = is_load_in | is_store_in;
    both   = is_load_in & is_store_in;
    f3_ok  = 1'b0;
    if (is_load_in)
      f3_ok = (funct3_in == 3'b000) || (funct3_in == 3'b001) ||
              (funct3_in == 3'b010) || (funct3_in == 3'b100) ||
              (funct3_in == 3'b101);
    else
      f3_ok = (funct3_in == 3'b000) || (funct3_in == 3'b001) ||
              (funct3_in == 3'b010);
    misal = ((funct3_in[1:0] == 2'b01) && busc_in[0]) ||
            ((funct3_in[1:0] == 2'b10) && (busc_in[1:0] != 2'b00));
    bad    = both | ~f3_ok | misal;
    accept = (state_q == IDLE) & valid_in & is_mem & ~bad;
    expire = (state_q == ACCESS) & ~dmem_ack & (cnt_q == CLAST);
    stall_out = accept |
                ((state_q == ACCESS) & ~dmem_ack & ~expire);
  end

  always_comb begin
    wd_n = store_data_in;
    be_n = 4'b1111;
    if (is_store_in) begin
      unique case (funct3_in[1:0])
        2'b00: begin
          wd_n = {4{store_data_in[7:0]}};
          be_n = 4'b0001 << busc_in[1:0];
        end
        2'b01: begin
          wd_n = {2{store_data_in[15:0]}};
          be_n = 4'b0011 << busc_in[1:0];
        end
        default: begin
          wd_n = store_data_in;
          be_n = 4'b1111;
        end
      endcase
    end
  end

  // Lane select by byte offset, then extend per funct3
  always_comb begin
    sh_data = dmem_rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_val = {{24{sh_data[7]}}, sh_data[7:0]};
      3'b100:  ld_val = {24'h0, sh_data[7:0]};
      3'b001:  ld_val = {{16{sh_data[15]}}, sh_data[15:0]};
      3'b101:  ld_val = {16'h0, sh_data[15:0]};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    res_d   = res_q;
    rd_d    = rd_q;
    wbv_d   = 1'b0;
    flt_d   = 1'b0;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdp_d   = rdp_q;
    case (state_q)
      IDLE: begin
        if (valid_in && !is_mem) begin
          res_d = busc_in;
          rd_d  = rd_in;
          wbv_d = (rd_in != 5'd0);
        end else if (valid_in && bad) begin
          flt_d = 1'b1;
        end else if (accept) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = is_store_in;
          addr_d  = {busc_in[31:2], 2'b00};
          wdata_d = wd_n;
          be_d    = be_n;
          cnt_d   = '0;
          f3_d    = funct3_in;
          off_d   = busc_in[1:0];
          rdp_d   = rd_in;
        end
      end
      default: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            res_d = ld_val;
            rd_d  = rdp_q;
            wbv_d = (rdp_q != 5'd0);
          end
        end else if (expire) begin
          state_d = IDLE;
          req_d   = 1'b0;
          flt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      wbv_q   <= 1'b0;
      flt_q   <= 1'b0;
      cnt_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdp_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      wbv_q   <= wbv_d;
      flt_q   <= flt_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdp_q   <= rdp_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign result_out   = res_q;
  assign rd_out       = rd_q;
  assign wb_valid_out = wbv_q;
  assign fault_out    = flt_q;

endmodule

// File: tb/tb_stage_ma_mem.sv
// Directed bench for stage_ma_mem with TIMEOUT = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stage_ma_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] busc_in;
  logic [31:0] store_data_in;
  logic [2:0]  funct3_in;
  logic        is_load_in;
  logic        is_store_in;
  logic [4:0]  rd_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] result_out;
  logic [4:0]  rd_out;
  logic        wb_valid_out;
  logic        fault_out;

  int tests = 0;
  int fails = 0;

  stage_ma_mem #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .busc_in       (busc_in),
    .store_data_in (store_data_in),
    .funct3_in     (funct3_in),
    .is_load_in    (is_load_in),
    .is_store_in   (is_store_in),
    .rd_in         (rd_in),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .result_out    (result_out),
    .rd_out        (rd_out),
    .wb_valid_out  (wb_valid_out),
    .fault_out     (fault_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_op(input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd);
    valid_in      = 1'b1;
    is_load_in    = ld;
    is_store_in   = ~ld;
    funct3_in     = f3;
    busc_in       = a;
    store_data_in = sd;
    rd_in         = rd;
  endtask

  task automatic idle_in();
    valid_in    = 1'b0;
    is_load_in  = 1'b0;
    is_store_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    busc_in = '0;
    store_data_in = '0;
    funct3_in = '0;
    is_load_in = 1'b0;
    is_store_in = 1'b0;
    rd_in = '0;
    dmem_rdata = '0;
    dmem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_res", result_out, 32'd0);
    chk("rst_rd", {27'b0, rd_out}, 32'd0);
    chk("rst_wb", {31'b0, wb_valid_out}, 32'd0);
    chk("rst_flt", {31'b0, fault_out}, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);

    // ALU pass-through
    valid_in = 1'b1;
    busc_in  = 32'h1234_5678;
    rd_in    = 5'd7;
    #1;
    chk("alu_stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("alu_res", result_out, 32'h1234_5678);
    chk("alu_rd", {27'b0, rd_out}, 32'd7);
    chk("alu_wb", {31'b0, wb_valid_out}, 32'd1);
    busc_in = 32'h0000_00AA;
    rd_in   = 5'd0;
    tick();
    chk("alu_rd0_wb", {31'b0, wb_valid_out}, 32'd0);
    chk("alu_rd0_res", result_out, 32'h0000_00AA);
    idle_in();
    tick();
    chk("alu_pulse", {31'b0, wb_valid_out}, 32'd0);

    // LB sign extension
    mem_op(1'b1, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
    #1;
    chk("lb_stall0", {31'b0, stall_out}, 32'd1);
    tick();
    chk("lb_req", {31'b0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_1000);
    chk("lb_we", {31'b0, dmem_we}, 32'd0);
    chk("lb_be", {28'b0, dmem_be}, 32'hF);
    dmem_rdata = 32'h80AB_CDEF;
    dmem_ack   = 1'b1;
    #1;
    chk("lb_stall_ack", {31'b0, stall_out}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    idle_in();
    chk("lb_res", result_out, 32'hFFFF_FF80);
    chk("lb_wb", {31'b0, wb_valid_out}, 32'd1);
    chk("lb_rd", {27'b0, rd_out}, 32'd5);
    chk("lb_req_low", {31'b0, dmem_req}, 32'd0);

    // LBU zero extension
    mem_op(1'b1, 3'b100, 32'h0000_1003, 32'h0, 5'd6);
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    idle_in();
    chk("lbu_res", result_out, 32'h0000_0080);
    chk("lbu_wb", {31'b0, wb_valid_out}, 32'd1);

    // SH byte enables
    mem_op(1'b0, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 5'd0);
    tick();
    chk("sh_we", {31'b0, dmem_we}, 32'd1);
    chk("sh_be", {28'b0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", dmem_addr, 32'h0000_2000);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    idle_in();
    chk("sh_wb", {31'b0, wb_valid_out}, 32'd0);
    chk("sh_req_low", {31'b0, dmem_req}, 32'd0);

    // SB lane replication
    mem_op(1'b0, 3'b000, 32'h0000_7001, 32'h1122_3344, 5'd4);
    tick();
    chk("sb_be", {28'b0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h4444_4444);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    idle_in();
    chk("sb_wb", {31'b0, wb_valid_out}, 32'd0);

    // LW with three ACCESS cycles
    mem_op(1'b1, 3'b010, 32'h0000_3000, 32'h0, 5'd9);
    tick();
    chk("ws_req1", {31'b0, dmem_req}, 32'd1);
    chk("ws_stall1", {31'b0, stall_out}, 32'd1);
    tick();
    chk("ws_req2", {31'b0, dmem_req}, 32'd1);
    chk("ws_addr2", dmem_addr, 32'h0000_3000);
    chk("ws_stall2", {31'b0, stall_out}, 32'd1);
    tick();
    chk("ws_req3", {31'b0, dmem_req}, 32'd1);
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_ack   = 1'b1;
    #1;
    chk("ws_stall3", {31'b0, stall_out}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    idle_in();
    chk("ws_res", result_out, 32'hDEAD_BEEF);
    chk("ws_wb", {31'b0, wb_valid_out}, 32'd1);
    chk("ws_req_low", {31'b0, dmem_req}, 32'd0);

    // Misaligned LW
    mem_op(1'b1, 3'b010, 32'h0000_0006, 32'h0, 5'd2);
    #1;
    chk("mis_stall", {31'b0, stall_out}, 32'd0);
    tick();
    idle_in();
    chk("mis_flt", {31'b0, fault_out}, 32'd1);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_wb", {31'b0, wb_valid_out}, 32'd0);
    tick();
    chk("mis_flt_pulse", {31'b0, fault_out}, 32'd0);
    chk("mis_req2", {31'b0, dmem_req}, 32'd0);

    // Illegal load funct3
    mem_op(1'b1, 3'b011, 32'h0000_0008, 32'h0, 5'd2);
    tick();
    idle_in();
    chk("f3_flt", {31'b0, fault_out}, 32'd1);
    chk("f3_req", {31'b0, dmem_req}, 32'd0);

    // Both class bits set
    mem_op(1'b1, 3'b010, 32'h0000_0008, 32'h0, 5'd2);
    is_store_in = 1'b1;
    tick();
    idle_in();
    chk("both_flt", {31'b0, fault_out}, 32'd1);
    chk("both_req", {31'b0, dmem_req}, 32'd0);

    // Timeout after 4 unacknowledged ACCESS cycles
    mem_op(1'b1, 3'b010, 32'h0000_4000, 32'h0, 5'd8);
    tick();
    chk("to_req1", {31'b0, dmem_req}, 32'd1);
    tick();
    tick();
    tick();
    chk("to_req4", {31'b0, dmem_req}, 32'd1);
    chk("to_stall4", {31'b0, stall_out}, 32'd0);
    chk("to_flt4", {31'b0, fault_out}, 32'd0);
    tick();
    idle_in();
    chk("to_flt", {31'b0, fault_out}, 32'd1);
    chk("to_req_low", {31'b0, dmem_req}, 32'd0);
    dmem_rdata = 32'h5555_5555;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("to_late_wb", {31'b0, wb_valid_out}, 32'd0);
    chk("to_flt_pulse", {31'b0, fault_out}, 32'd0);

    // Reset in the middle of ACCESS
    mem_op(1'b1, 3'b010, 32'h0000_5000, 32'h0, 5'd3);
    tick();
    chk("rsa_req", {31'b0, dmem_req}, 32'd1);
    idle_in();
    rst = 1'b1;
    tick();
    chk("rsa_req0", {31'b0, dmem_req}, 32'd0);
    chk("rsa_res", result_out, 32'd0);
    chk("rsa_addr", dmem_addr, 32'd0);
    chk("rsa_rd", {27'b0, rd_out}, 32'd0);
    tick();
    rst = 1'b0;
    dmem_rdata = 32'h0000_1234;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("rsa_wb", {31'b0, wb_valid_out}, 32'd0);
    chk("rsa_flt", {31'b0, fault_out}, 32'd0);
    chk("rsa_res2", result_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
